// File: rtl/fir_coef_loader.sv
// Coefficient reload sequencer for the FIR bank: mutes audio, drains the current pass,
// resets the bank write address, writes MSB/LSB tap pairs from a host byte stream, then restores audio.
`timescale 1ns/1ps

module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,
  parameter int SETTLE_CLKS = 2   // 1..256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audio_en_req,
  input  logic       load_start,
  input  logic [3:0] load_filter,
  input  logic [7:0] taps_per_filter,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       fir_busy,
  input  logic       wr_addr_zero,
  output logic       audio_en,
  output logic       coef_addr_rst,
  output logic       coefficient_wr_en,
  output logic [3:0] coef_select,
  output logic [7:0] coef_wr_msb_data,
  output logic [7:0] coef_wr_lsb_data,
  output logic       busy,
  output logic       load_done,
  output logic       load_error,
  output logic [7:0] tap_count
);

  localparam logic [4:0] FILTER_LIMIT = 5'(NUM_FILTERS);
  localparam logic [7:0] SETTLE_LAST  = (SETTLE_CLKS > 1) ? 8'(SETTLE_CLKS - 1) : 8'd0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN,
    S_ADDR_RST,
    S_ADDR_CHK,
    S_MSB,
    S_LSB,
    S_WRITE,
    S_SETTLE,
    S_RESTORE
  } state_t;

  state_t     state_reg, state_next;
  logic       start_load, done_next, error_next, take;

  logic       audio_en_reg, coef_addr_rst_reg, wr_en_reg, byte_ready_reg;
  logic       busy_reg, load_done_reg, load_error_reg;
  logic [3:0] coef_select_reg;
  logic [7:0] msb_reg, lsb_reg, taps_reg, tap_count_reg, settle_cnt_reg;
  logic       drain_idle_reg;

  // byte_ready_reg is a registered function of the state, so acceptance never loops through byte_valid
  assign take = byte_valid & byte_ready_reg;

  always_comb begin
    state_next = state_reg;
    start_load = 1'b0;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (load_start) begin
          if ({1'b0, load_filter} >= FILTER_LIMIT) begin
            error_next = 1'b1;
          end else begin
            start_load = 1'b1;
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!fir_busy && drain_idle_reg) state_next = S_ADDR_RST;
      end
      S_ADDR_RST: state_next = S_ADDR_CHK;
      S_ADDR_CHK: begin
        if (wr_addr_zero) begin
          state_next = (taps_reg == 8'd0) ? S_SETTLE : S_MSB;
        end else begin
          done_next  = 1'b1;
          error_next = 1'b1;
          state_next = S_RESTORE;
        end
      end
      S_MSB:   if (take) state_next = S_LSB;
      S_LSB:   if (take) state_next = S_WRITE;
      // tap_count_reg already includes the write being issued this cycle
      S_WRITE: state_next = (tap_count_reg == taps_reg) ? S_SETTLE : S_MSB;
      S_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          done_next  = 1'b1;
          state_next = S_RESTORE;
        end
      end
      S_RESTORE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase

    // Abort wins over any byte acceptance or pending write in the same cycle
    if (abort && (state_reg != S_IDLE) && (state_reg != S_RESTORE)) begin
      state_next = S_RESTORE;
      done_next  = 1'b1;
      error_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      audio_en_reg      <= 1'b0;
      coef_addr_rst_reg <= 1'b0;
      wr_en_reg         <= 1'b0;
      byte_ready_reg    <= 1'b0;
      busy_reg          <= 1'b0;
      load_done_reg     <= 1'b0;
      load_error_reg    <= 1'b0;
      drain_idle_reg    <= 1'b0;
      settle_cnt_reg    <= 8'd0;
    end else begin
      state_reg         <= state_next;
      audio_en_reg      <= ((state_next == S_IDLE) || (state_next == S_RESTORE)) ? audio_en_req : 1'b0;
      coef_addr_rst_reg <= (state_next == S_ADDR_RST);
      wr_en_reg         <= (state_next == S_WRITE);
      byte_ready_reg    <= (state_next == S_MSB) || (state_next == S_LSB);
      busy_reg          <= (state_next != S_IDLE);
      load_done_reg     <= done_next;
      load_error_reg    <= error_next;
      drain_idle_reg    <= (state_reg == S_DRAIN) && !fir_busy;
      settle_cnt_reg    <= (state_reg == S_SETTLE) ? settle_cnt_reg + 8'd1 : 8'd0;
    end
  end

  // Bytes and select stay put between writes so the bank sees stable data around each strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_select_reg <= 4'd0;
      taps_reg        <= 8'd0;
      tap_count_reg   <= 8'd0;
      msb_reg         <= 8'd0;
      lsb_reg         <= 8'd0;
    end else begin
      if (start_load) begin
        coef_select_reg <= load_filter;
        taps_reg        <= taps_per_filter;
        tap_count_reg   <= 8'd0;
      end else if (state_next == S_WRITE) begin
        tap_count_reg   <= tap_count_reg + 8'd1;
      end
      if ((state_reg == S_MSB) && (state_next == S_LSB))   msb_reg <= byte_data;
      if ((state_reg == S_LSB) && (state_next == S_WRITE)) lsb_reg <= byte_data;
    end
  end

  assign audio_en          = audio_en_reg;
  assign coef_addr_rst     = coef_addr_rst_reg;
  assign coefficient_wr_en = wr_en_reg;
  assign coef_select       = coef_select_reg;
  assign coef_wr_msb_data  = msb_reg;
  assign coef_wr_lsb_data  = lsb_reg;
  assign byte_ready        = byte_ready_reg;
  assign busy              = busy_reg;
  assign load_done         = load_done_reg;
  assign load_error        = load_error_reg;
  assign tap_count         = tap_count_reg;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed + randomized bench for fir_coef_loader; expected writes come from the byte
// stream paired into {msb,lsb} taps, checked with immediate assertions.
`timescale 1ns/1ps

module tb_fir_coef_loader;
  localparam int NUM_FILTERS = 4;
  localparam int SETTLE_CLKS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       audio_en_req = 1'b1;
  logic       load_start = 1'b0;
  logic [3:0] load_filter = 4'd0;
  logic [7:0] taps_per_filter = 8'd0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_ready;
  logic       fir_busy = 1'b0;
  logic       wr_addr_zero = 1'b1;
  logic       audio_en, coef_addr_rst, coefficient_wr_en;
  logic [3:0] coef_select;
  logic [7:0] coef_wr_msb_data, coef_wr_lsb_data;
  logic       busy, load_done, load_error;
  logic [7:0] tap_count;

  fir_coef_loader #(.NUM_FILTERS(NUM_FILTERS), .SETTLE_CLKS(SETTLE_CLKS)) dut (
    .clk(clk), .reset(reset), .audio_en_req(audio_en_req), .load_start(load_start),
    .load_filter(load_filter), .taps_per_filter(taps_per_filter), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fir_busy(fir_busy), .wr_addr_zero(wr_addr_zero), .audio_en(audio_en),
    .coef_addr_rst(coef_addr_rst), .coefficient_wr_en(coefficient_wr_en),
    .coef_select(coef_select), .coef_wr_msb_data(coef_wr_msb_data),
    .coef_wr_lsb_data(coef_wr_lsb_data), .busy(busy), .load_done(load_done),
    .load_error(load_error), .tap_count(tap_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host byte pattern (owned by the main sequence) and epoch used to restart monitor/driver
  int         epoch = 0;
  logic [7:0] pat [0:63];
  int         pat_len = 0;
  bit         bp_mode = 1'b0;

  // Monitor: observes the bank side on the falling edge
  int          mon_epoch = 0;
  logic [19:0] wr_q[$];
  int n_addr_rst = 0, n_done = 0, n_err = 0, n_busy = 0, aud_viol = 0;
  int addr_rst_cyc = 0, done_cyc = 0, err_cyc = 0, wr_cyc = 0;
  bit take = 1'b0;

  always @(negedge clk) begin
    if (mon_epoch != epoch) begin
      mon_epoch  <= epoch;
      wr_q.delete();
      n_addr_rst <= 0;
      n_done     <= 0;
      n_err      <= 0;
      n_busy     <= 0;
      aud_viol   <= 0;
    end else begin
      if (coefficient_wr_en) begin
        wr_q.push_back({coef_select, coef_wr_msb_data, coef_wr_lsb_data});
        wr_cyc <= cyc;
      end
      if (coef_addr_rst) begin n_addr_rst <= n_addr_rst + 1; addr_rst_cyc <= cyc; end
      if (load_done)     begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (load_error)    begin n_err <= n_err + 1; err_cyc <= cyc; end
      if (busy) n_busy <= n_busy + 1;
      // While loading, audio may only be live in the cycle that reports completion
      if (audio_en && busy && !load_done) aud_viol <= aud_viol + 1;
    end
    take <= byte_valid && byte_ready && !abort;
  end

  // Byte driver: presents pat[] in order, advancing only on accepted bytes
  int drv_epoch = 0;
  int pidx = 0;

  function automatic int nidx();
    if (drv_epoch != epoch) return 0;
    return take ? pidx + 1 : pidx;
  endfunction

  always @(posedge clk) begin
    #1;
    pidx       <= nidx();
    drv_epoch  <= epoch;
    byte_valid <= (nidx() < pat_len) && (!bp_mode || ($urandom_range(0, 1) == 1));
    byte_data  <= pat[nidx() % 64];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_epoch();
    epoch++;
    step(1);
  endtask

  task automatic set_random_pattern(input int n);
    pat_len = 2 * n;
    for (int i = 0; i < 2 * n; i++) pat[i] = 8'($urandom);
  endtask

  task automatic pulse_start(input logic [3:0] f, input logic [7:0] n);
    load_filter     = f;
    taps_per_filter = n;
    load_start      = 1'b1;
    step(1);
    load_start      = 1'b0;
    load_filter     = 4'($urandom);
    taps_per_filter = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (n_done > 0) begin ok = 1'b1; break; end
      step(1);
    end
    chk($sformatf("%s done_seen", tag), 32'(ok), 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [3:0] f, input int n);
    chk($sformatf("%s write_count", tag), wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size())
        chk($sformatf("%s write%0d", tag, i), 32'(wr_q[i]), 32'({f, pat[2*i], pat[2*i+1]}));
    end
  endtask

  task automatic run_load(input string tag, input logic [3:0] f, input int n, input bit bp);
    new_epoch();
    bp_mode = bp;
    pulse_start(f, 8'(n));
    step(2);
    // a second start while busy must be ignored
    load_filter = 4'(f + 1);
    load_start  = 1'b1;
    step(1);
    load_start  = 1'b0;
    wait_done(tag, 3000);
    step(3);
    check_writes(tag, f, n);
    chk($sformatf("%s tap_count", tag), 32'(tap_count), n);
    chk($sformatf("%s errors", tag), n_err, 0);
    chk($sformatf("%s done_pulses", tag), n_done, 1);
    chk($sformatf("%s addr_rst_pulses", tag), n_addr_rst, 1);
    chk($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    chk($sformatf("%s audio_restored", tag), 32'(audio_en), 32'(audio_en_req));
    chk($sformatf("%s audio_muted", tag), aud_viol, 0);
    if (n > 0)
      chk($sformatf("%s settle_gap", tag), done_cyc - wr_cyc, SETTLE_CLKS + 1);
    else
      chk($sformatf("%s settle_gap_min", tag), 32'((done_cyc - addr_rst_cyc) >= SETTLE_CLKS + 1), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int fall_cyc;
    bit reached;
    logic [3:0] rf;
    int rn;

    // Reset state
    step(2);
    chk("rst audio_en", 32'(audio_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst tap_count", 32'(tap_count), 32'd0);
    chk("rst coef_select", 32'(coef_select), 32'd0);
    chk("rst strobes", 32'({coef_addr_rst, coefficient_wr_en, load_done, load_error, byte_ready}), 32'd0);
    chk("rst data", 32'({coef_wr_msb_data, coef_wr_lsb_data}), 32'd0);
    reset = 1'b0;
    step(2);
    chk("idle audio passthrough", 32'(audio_en), 32'd1);

    // Nominal load, filter 2, taps 3
    pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56;
    pat[3] = 8'h78; pat[4] = 8'h9A; pat[5] = 8'hBC;
    pat_len = 6;
    run_load("nominal", 4'd2, 3, 1'b0);

    // Bad filter index
    new_epoch();
    pulse_start(4'(NUM_FILTERS + $urandom_range(0, 15 - NUM_FILTERS)), 8'd3);
    step(3);
    chk("badidx error", n_err, 1);
    chk("badidx done", n_done, 0);
    chk("badidx busy", n_busy, 0);
    chk("badidx addr_rst", n_addr_rst, 0);
    chk("badidx writes", wr_q.size(), 0);
    chk("badidx audio", 32'(audio_en), 32'(audio_en_req));

    // Address handshake failure
    wr_addr_zero = 1'b0;
    set_random_pattern(2);
    new_epoch();
    pulse_start(4'd3, 8'd2);
    wait_done("addrfail", 500);
    step(3);
    chk("addrfail error", n_err, 1);
    chk("addrfail done", n_done, 1);
    chk("addrfail coincident", done_cyc - err_cyc, 0);
    chk("addrfail writes", wr_q.size(), 0);
    chk("addrfail audio", 32'(audio_en), 32'(audio_en_req));
    chk("addrfail busy", 32'(busy), 32'd0);
    wr_addr_zero = 1'b1;

    // Drain wait on a busy FIR pass
    fir_busy = 1'b1;
    set_random_pattern(2);
    new_epoch();
    pulse_start(4'd0, 8'd2);
    step(20);
    chk("drain no addr_rst", n_addr_rst, 0);
    chk("drain audio", 32'(audio_en), 32'd0);
    fir_busy = 1'b0;
    fall_cyc = cyc;
    wait_done("drain", 500);
    step(3);
    chk("drain addr_rst delay", addr_rst_cyc - fall_cyc, 2);
    check_writes("drain", 4'd0, 2);
    chk("drain audio muted", aud_viol, 0);

    // Abort while waiting for the LSB of tap 2 of 4
    set_random_pattern(4);
    pat_len = 3;
    new_epoch();
    pulse_start(4'd1, 8'd4);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wr_q.size() == 1 && pidx == pat_len && byte_ready) begin reached = 1'b1; break; end
      step(1);
    end
    chk("abort reached lsb", 32'(reached), 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(1);
    chk("abort idle in 2", 32'(busy), 32'd0);
    step(2);
    chk("abort tap_count", 32'(tap_count), 32'd1);
    chk("abort done", n_done, 1);
    chk("abort error", n_err, 1);
    chk("abort coincident", done_cyc - err_cyc, 0);
    check_writes("abort", 4'd1, 1);
    chk("abort audio", 32'(audio_en), 32'(audio_en_req));

    // Zero taps
    pat_len = 0;
    run_load("taps0", 4'd3, 0, 1'b1);

    // Randomized loads with backpressure
    for (int k = 0; k < 6; k++) begin
      audio_en_req = 1'($urandom_range(0, 1));
      rf = 4'($urandom_range(0, NUM_FILTERS - 1));
      rn = int'($urandom_range(1, 6));
      set_random_pattern(rn);
      run_load($sformatf("rand%0d", k), rf, rn, 1'b1);
    end

    // Asynchronous reset in the middle of a load
    audio_en_req = 1'b1;
    set_random_pattern(5);
    new_epoch();
    pulse_start(4'd2, 8'd5);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wr_q.size() >= 2) begin reached = 1'b1; break; end
      step(1);
    end
    chk("arst reached", 32'(reached), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst audio", 32'(audio_en), 32'd0);
    chk("arst strobes", 32'({coef_addr_rst, coefficient_wr_en, byte_ready, load_done}), 32'd0);
    chk("arst tap_count", 32'(tap_count), 32'd0);
    step(1);
    reset = 1'b0;
    step(2);
    chk("arst audio back", 32'(audio_en), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
